// File: rtl/mul16_mitchell_core_if.sv
//------------------------------------------------------------------------------
// Module  : mul16_mitchell_core_if
// Brief   : Operand/result bundle for the Mitchell log-domain 16x16 multiplier.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mul16_mitchell_core_if;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [31:0] c;

  modport master (
    output in_valid,
    output a,
    output b,
    input  out_valid,
    input  c
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    output out_valid,
    output c
  );
endinterface

`default_nettype wire

// File: rtl/mul16_mitchell_core.sv
//------------------------------------------------------------------------------
// Module  : mul16_mitchell_core
// Brief   : Unsigned 16x16 -> 32 Mitchell approximate multiplier, 1/cycle.
//           Define MUL16_MITCHELL_PIPE2_EN for a 2-cycle (two-stage) build.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mul16_mitchell_core (
  input  wire logic             clk,
  input  wire logic             rst_n,
  mul16_mitchell_core_if.slave  bus
);

  // Highest set bit index; the value for a zero operand is irrelevant
  // because the zero flag overrides the product.
  function automatic logic [3:0] lead_one(input logic [15:0] v);
    lead_one = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) lead_one = 4'(i);
    end
  endfunction

  logic [3:0]  w_ka;
  logic [3:0]  w_kb;
  logic [14:0] w_fa;
  logic [14:0] w_fb;
  logic [15:0] w_s;
  logic        w_zero;

  always_comb begin
    w_ka   = lead_one(bus.a);
    w_kb   = lead_one(bus.b);
    w_fa   = 15'((bus.a & ~(16'd1 << w_ka)) << (4'd15 - w_ka));
    w_fb   = 15'((bus.b & ~(16'd1 << w_kb)) << (4'd15 - w_kb));
    w_s    = {1'b0, w_fa} + {1'b0, w_fb};
    w_zero = (bus.a == 16'd0) || (bus.b == 16'd0);
  end

  logic [3:0]  w_st_ka;
  logic [3:0]  w_st_kb;
  logic [15:0] w_st_s;
  logic        w_st_zero;
  logic        w_st_valid;

`ifdef MUL16_MITCHELL_PIPE2_EN
  logic [3:0]  r_ka;
  logic [3:0]  r_kb;
  logic [15:0] r_s;
  logic        r_zero;
  logic        r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ka    <= 4'd0;
      r_kb    <= 4'd0;
      r_s     <= 16'd0;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_ka   <= w_ka;
        r_kb   <= w_kb;
        r_s    <= w_s;
        r_zero <= w_zero;
      end
    end
  end

  assign w_st_ka    = r_ka;
  assign w_st_kb    = r_kb;
  assign w_st_s     = r_s;
  assign w_st_zero  = r_zero;
  assign w_st_valid = r_valid;
`else
  assign w_st_ka    = w_ka;
  assign w_st_kb    = w_kb;
  assign w_st_s     = w_s;
  assign w_st_zero  = w_zero;
  assign w_st_valid = bus.in_valid;
`endif

  logic [4:0]  w_k;
  logic [4:0]  w_k1;
  logic [47:0] w_wide;
  logic [31:0] w_prod;

  // A carry out of the fraction sum means the antilog mantissa is S itself
  // with one extra doubling; otherwise the implicit leading one is restored.
  always_comb begin
    w_k    = {1'b0, w_st_ka} + {1'b0, w_st_kb};
    w_k1   = w_k + 5'd1;
    w_wide = w_st_s[15] ? (48'(w_st_s) << w_k1)
                        : (48'({1'b1, w_st_s[14:0]}) << w_k);
    w_prod = w_st_zero ? 32'd0 : 32'(w_wide >> 15);
  end

  logic        r_out_valid;
  logic [31:0] r_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_c         <= 32'd0;
    end else begin
      r_out_valid <= w_st_valid;
      if (w_st_valid) r_c <= w_prod;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.c         = r_c;

endmodule

`default_nettype wire

// File: tb/tb_mul16_mitchell_core.sv
//------------------------------------------------------------------------------
// Module  : tb_mul16_mitchell_core
// Brief   : Directed and streaming self-checking bench for mul16_mitchell_core.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mul16_mitchell_core;

`ifdef MUL16_MITCHELL_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic        hv [0:1023];
  logic [31:0] hc [0:1023];

  mul16_mitchell_core_if u_if ();

  mul16_mitchell_core u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mref(input logic [15:0] x, input logic [15:0] y);
    longint unsigned fx, fy, s, r;
    int kx, ky;
    if (x == 16'd0 || y == 16'd0) return 32'd0;
    kx = 0;
    while ((x >> (kx + 1)) != 0) kx++;
    ky = 0;
    while ((y >> (ky + 1)) != 0) ky++;
    fx = (longint'(x) - (64'd1 << kx)) * (64'd1 << (15 - kx));
    fy = (longint'(y) - (64'd1 << ky)) * (64'd1 << (15 - ky));
    s  = fx + fy;
    if (s < 64'd32768) r = ((64'd32768 + s) * (64'd1 << (kx + ky))) / 64'd32768;
    else               r = (s * (64'd1 << (kx + ky + 1))) / 64'd32768;
    return r[31:0];
  endfunction

  // One isolated pair: result expected LAT edges after the capture edge.
  task automatic one(input string tag, input logic [15:0] x, input logic [15:0] y,
                     input logic [31:0] exp);
    @(negedge clk);
    u_if.in_valid = 1'b1;
    u_if.a        = x;
    u_if.b        = y;
    @(negedge clk);
    u_if.in_valid = 1'b0;
    u_if.a        = 16'hDEAD;
    u_if.b        = 16'hBEEF;
    repeat (LAT - 1) @(negedge clk);
    check({tag, "_v"}, 64'(u_if.out_valid), 64'd1);
    check(tag, 64'(u_if.c), 64'(exp));
  endtask

  task automatic rand_pair(output logic [15:0] x, output logic [15:0] y);
    int sel;
    sel = $urandom_range(0, 9);
    x = 16'($urandom());
    y = 16'($urandom());
    if (sel == 0) x = 16'd0;
    if (sel == 1) y = 16'd1 << $urandom_range(0, 15);
    if (sel == 2) x = 16'hFFFF;
    if (sel == 3) y = 16'($urandom_range(1, 15));
  endtask

  task automatic stream(input int n, input string tag);
    logic [15:0] x, y;
    for (int i = 0; i < n + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) begin
        check({tag, "_v"}, 64'(u_if.out_valid), 64'(hv[i - LAT]));
        if (hv[i - LAT]) check({tag, "_c"}, 64'(u_if.c), 64'(hc[i - LAT]));
      end
      if (i < n) begin
        rand_pair(x, y);
        u_if.in_valid = 1'b1;
        u_if.a        = x;
        u_if.b        = y;
        hv[i]         = 1'b1;
        hc[i]         = mref(x, y);
      end else begin
        u_if.in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.a        = 16'd0;
    u_if.b        = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_v", 64'(u_if.out_valid), 64'd0);
    check("rst_c", 64'(u_if.c), 64'd0);
    rst_n = 1'b1;

    one("zero_a",  16'd0,     16'd1234,  32'd0);
    one("zero_b",  16'd777,   16'd0,     32'd0);
    one("one_one", 16'd1,     16'd1,     32'd1);
    one("pow2",    16'd256,   16'd1024,  32'd262144);
    one("pow2_hi", 16'd32768, 16'd2,     32'd65536);
    one("carry33", 16'd3,     16'd3,     32'd8);
    one("max",     16'hFFFF,  16'hFFFF,  32'd4294836224);
    one("nocarry", 16'd5,     16'd6,     32'd28);

    @(negedge clk);
    check("idle_v", 64'(u_if.out_valid), 64'd0);
    check("hold_c", 64'(u_if.c), 64'd28);

    stream(600, "s1");

    // Mid-stream asynchronous reset with pairs still in flight
    @(negedge clk);
    u_if.in_valid = 1'b1;
    u_if.a        = 16'hFFFF;
    u_if.b        = 16'hFFFF;
    repeat (LAT + 1) @(negedge clk);
    check("pre_rst_v", 64'(u_if.out_valid), 64'd1);
    u_if.a = 16'd5;
    u_if.b = 16'd6;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_v", 64'(u_if.out_valid), 64'd0);
    check("arst_c", 64'(u_if.c), 64'd0);
    repeat (2) @(negedge clk);
    rst_n         = 1'b1;
    u_if.in_valid = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      check("post_rst_v", 64'(u_if.out_valid), 64'd0);
      check("post_rst_c", 64'(u_if.c), 64'd0);
    end

    stream(500, "s2");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
